fb_pixel_loader: RTL and testbench

Write-side companion to the display's frame-buffer read path. Accepts a byte stream (for example from a UART receiver) over a valid/ready handshake and packs each pair of bytes into one 12-bit RGB444 pixel. Writes pixels in raster order into the 128×128 frame-buffer BRAM. Writes are issued only while the display is in blanking, so the single BRAM port is never contended with the scan-out reader.

---
 rtl/fb_pkg.sv | 20 ++
 rtl/fb_addr_counter.sv | 43 ++++
 rtl/fb_pixel_loader.sv | 97 +++++++++
 tb/tb_fb_pixel_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry defaults, loader states and RGB444 field layout.
package fb_pkg;

  localparam int FB_ADDR_W = 7;
  localparam int FB_RGB_W  = 12;
  localparam logic [FB_ADDR_W-1:0] FB_LAST = '1;

  // RGB444 packing {B, G, R}, also used by the display read path.
  localparam int FB_FIELD_W = 4;
  localparam int FB_R_LSB   = 0;
  localparam int FB_G_LSB   = 4;
  localparam int FB_B_LSB   = 8;

  typedef enum logic [1:0] {
    LO,
    HI,
    PEND
  } loader_state_t;

endpackage

// File: rtl/fb_addr_counter.sv
// Raster row/column write address with wrap and a flag for the last pixel of the frame.
module fb_addr_counter
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              last
);

  localparam logic [ADDR_W-1:0] MAX = '1;

  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;

  // Clear beats advance so a restart during a write still lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (advance) begin
      if (r_col == MAX) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = (r_row == MAX) && (r_col == MAX);

endmodule

// File: rtl/fb_pixel_loader.sv
// Packs byte pairs into RGB444 pixels and writes them in raster order during display blanking.
module fb_pixel_loader
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int RGB_W  = FB_RGB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              frame_start,
  input  logic              blank,
  output logic [ADDR_W-1:0] wr_row,
  output logic [ADDR_W-1:0] wr_col,
  output logic [RGB_W-1:0]  wr_rgb,
  output logic              wr_en,
  output logic              frame_done
);

  loader_state_t r_state;
  loader_state_t w_state_next;

  logic             w_ready;
  logic             w_accept;
  logic             w_wr_en_next;
  logic             w_done_next;
  logic             w_last;
  logic             r_wr_en;
  logic             r_frame_done;
  logic [RGB_W-1:0] r_rgb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LO;
    else       r_state <= w_state_next;
  end

  // A held pixel is only released while the display is not reading the BRAM.
  always_comb begin
    w_state_next = r_state;
    w_wr_en_next = 1'b0;
    w_done_next  = 1'b0;
    w_ready      = (r_state != PEND) && !frame_start;
    w_accept     = in_valid && w_ready;
    if (frame_start) begin
      w_state_next = LO;
    end else begin
      case (r_state)
        LO:   if (w_accept) w_state_next = HI;
        HI:   if (w_accept) w_state_next = PEND;
        PEND: if (blank) begin
          w_state_next = LO;
          w_wr_en_next = 1'b1;
          w_done_next  = w_last;
        end
        default: w_state_next = LO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb        <= '0;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= w_wr_en_next;
      r_frame_done <= w_done_next;
      if (w_accept && (r_state == LO)) begin
        r_rgb[FB_G_LSB +: FB_FIELD_W] <= in_data[7:4];
        r_rgb[FB_R_LSB +: FB_FIELD_W] <= in_data[3:0];
      end
      if (w_accept && (r_state == HI)) begin
        r_rgb[FB_B_LSB +: FB_FIELD_W] <= in_data[3:0];
      end
    end
  end

  fb_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk    (clk),
    .reset  (reset),
    .clear  (frame_start),
    .advance(r_wr_en),
    .row    (wr_row),
    .col    (wr_col),
    .last   (w_last)
  );

  assign in_ready   = w_ready;
  assign wr_rgb     = r_rgb;
  assign wr_en      = r_wr_en;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fb_pixel_loader.sv
// Self-checking bench for fb_pixel_loader: vector table, directed corner sequences and random traffic vs a pixel-index model.
module tb_fb_pixel_loader;

  localparam int NPIX = 128 * 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       frame_start = 1'b0;
  logic       blank = 1'b0;
  logic [6:0] wr_row;
  logic [6:0] wr_col;
  logic [11:0] wr_rgb;
  logic       wr_en;
  logic       frame_done;

  fb_pixel_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frame_start(frame_start),
    .blank      (blank),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_rgb     (wr_rgb),
    .wr_en      (wr_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: linear pixel index, bytes collected for the current pixel (2 = held), registered strobes.
  int         mIdx;
  int         mBytes;
  logic [11:0] mRgb;
  bit         mWr;
  bit         mDone;

  int wrCount, doneCount;
  int lastRow, lastCol, doneRow, doneCol;
  logic [11:0] lastRgb;

  typedef struct {
    bit          fs;
    bit          valid;
    logic [7:0]  data;
    bit          blank;
    bit          eReady;
    bit          eWr;
    int          eRow;
    int          eCol;
    logic [11:0] eRgb;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mIdx = 0; mBytes = 0; mRgb = '0; mWr = 0; mDone = 0;
  endtask

  task automatic applyStimulus(input bit fs, input bit valid, input logic [7:0] data, input bit bl);
    bit expReady;
    bit nWr, nDone;
    int nIdx;
    @(negedge clk);
    frame_start = fs; in_valid = valid; in_data = data; blank = bl;
    #1;
    expReady = (mBytes < 2) && !fs;
    checkOutput("ready", int'(in_ready), int'(expReady));
    checkOutput("wr_en", int'(wr_en), int'(mWr));
    checkOutput("done", int'(frame_done), int'(mDone));
    checkOutput("row", int'(wr_row), mIdx / 128);
    checkOutput("col", int'(wr_col), mIdx % 128);
    checkOutput("rgb", int'(wr_rgb), int'(mRgb));
    if (wr_en) begin
      wrCount++; lastRow = int'(wr_row); lastCol = int'(wr_col); lastRgb = wr_rgb;
    end
    if (frame_done) begin
      doneCount++; doneRow = int'(wr_row); doneCol = int'(wr_col);
    end
    nIdx = mWr ? (mIdx + 1) % NPIX : mIdx;
    nWr = 0; nDone = 0;
    if (fs) begin
      nIdx = 0; mBytes = 0;
    end else if (valid && expReady) begin
      if (mBytes == 0) mRgb[7:0] = data;
      else             mRgb[11:8] = data[3:0];
      mBytes++;
    end else if (mBytes == 2 && bl) begin
      nWr = 1; nDone = (mIdx == NPIX - 1); mBytes = 0;
    end
    mIdx = nIdx; mWr = nWr; mDone = nDone;
  endtask

  task automatic sendPixel(input logic [7:0] b0, input logic [7:0] b1);
    applyStimulus(0, 1, b0, 1);
    applyStimulus(0, 1, b1, 1);
    applyStimulus(0, 0, 8'h00, 1);
  endtask

  initial begin
    vecs[0]  = '{0, 1, 8'h5A, 1, 1, 0, 0, 0, 12'h000};
    vecs[1]  = '{0, 1, 8'h03, 1, 1, 0, 0, 0, 12'h05A};
    vecs[2]  = '{0, 1, 8'h77, 1, 0, 0, 0, 0, 12'h35A};
    vecs[3]  = '{0, 0, 8'h00, 1, 1, 1, 0, 0, 12'h35A};
    vecs[4]  = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 12'h35A};
    vecs[5]  = '{0, 1, 8'hFF, 0, 1, 0, 0, 1, 12'h35A};
    vecs[6]  = '{0, 1, 8'hE1, 0, 1, 0, 0, 1, 12'h3FF};
    vecs[7]  = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 12'h1FF};
    vecs[8]  = '{0, 1, 8'h99, 0, 0, 0, 0, 1, 12'h1FF};
    vecs[9]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 12'h1FF};
    vecs[10] = '{0, 0, 8'h00, 0, 1, 1, 0, 1, 12'h1FF};
    vecs[11] = '{1, 1, 8'h44, 1, 0, 0, 0, 2, 12'h1FF};
    vecs[12] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 12'h1FF};

    modelReset();
    wrCount = 0; doneCount = 0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rstWrEn", int'(wr_en), 0);
    checkOutput("rstRgb", int'(wr_rgb), 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].fs, vecs[i].valid, vecs[i].data, vecs[i].blank);
      checkOutput($sformatf("vec%0d.ready", i), int'(in_ready), int'(vecs[i].eReady));
      checkOutput($sformatf("vec%0d.wr", i), int'(wr_en), int'(vecs[i].eWr));
      checkOutput($sformatf("vec%0d.row", i), int'(wr_row), vecs[i].eRow);
      checkOutput($sformatf("vec%0d.col", i), int'(wr_col), vecs[i].eCol);
      checkOutput($sformatf("vec%0d.rgb", i), int'(wr_rgb), int'(vecs[i].eRgb));
    end

    // Pixel held through 20 cycles of active display.
    applyStimulus(0, 1, 8'hA5, 0);
    applyStimulus(0, 1, 8'h0B, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 8'($urandom), 0);
      checkOutput("holdReady", int'(in_ready), 0);
      checkOutput("holdWr", int'(wr_en), 0);
      checkOutput("holdRgb", int'(wr_rgb), 12'hBA5);
    end
    applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("holdRelWr", int'(wr_en), 1);
    checkOutput("holdRelRgb", int'(wr_rgb), 12'hBA5);
    applyStimulus(1, 0, 8'h00, 1);

    // Row boundary, then a complete frame.
    wrCount = 0; doneCount = 0;
    for (int i = 0; i < 128; i++) sendPixel(8'($urandom), 8'($urandom));
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("row0Count", wrCount, 128);
    checkOutput("row0LastRow", lastRow, 0);
    checkOutput("row0LastCol", lastCol, 127);
    sendPixel(8'h12, 8'h34);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("row1Row", lastRow, 1);
    checkOutput("row1Col", lastCol, 0);
    for (int i = 0; i < NPIX - 129; i++) sendPixel(8'($urandom), 8'($urandom));
    applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("frameWrites", wrCount, NPIX);
    checkOutput("frameDoneCount", doneCount, 1);
    checkOutput("frameDoneRow", doneRow, 127);
    checkOutput("frameDoneCol", doneCol, 127);
    checkOutput("wrapRow", int'(wr_row), 0);
    checkOutput("wrapCol", int'(wr_col), 0);

    // Random traffic with occasional restarts.
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                    8'($urandom), $urandom_range(0, 2) != 0);

    // Restart discards a partial pixel and refuses the coincident byte.
    applyStimulus(1, 0, 8'h00, 1);
    applyStimulus(0, 1, 8'h11, 1);
    applyStimulus(1, 1, 8'h22, 1);
    checkOutput("fsReady", int'(in_ready), 0);
    sendPixel(8'hAB, 8'h0C);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("fsRgb", int'(lastRgb), 12'hCAB);
    checkOutput("fsRow", lastRow, 0);
    checkOutput("fsCol", lastCol, 0);

    // Restart during a write: write lands at the old address, then (0,0).
    applyStimulus(0, 1, 8'h12, 1);
    applyStimulus(0, 1, 8'h03, 1);
    applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(1, 0, 8'h00, 1);
    checkOutput("fsWrCol", lastCol, 1);
    checkOutput("fsWrRgb", int'(lastRgb), 12'h312);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("fsWrNextCol", int'(wr_col), 0);

    // Asynchronous reset while a pixel is pending at (5,9).
    applyStimulus(1, 0, 8'h00, 1);
    for (int i = 0; i < 5 * 128 + 9; i++) sendPixel(8'($urandom), 8'($urandom));
    applyStimulus(0, 1, 8'h6C, 0);
    applyStimulus(0, 1, 8'h0F, 0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("pendRow", int'(wr_row), 5);
    checkOutput("pendCol", int'(wr_col), 9);
    checkOutput("pendReady", int'(in_ready), 0);
    @(negedge clk);
    blank = 1'b1;
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRow", int'(wr_row), 0);
    checkOutput("asyncCol", int'(wr_col), 0);
    checkOutput("asyncRgb", int'(wr_rgb), 0);
    checkOutput("asyncWr", int'(wr_en), 0);
    checkOutput("asyncDone", int'(frame_done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    wrCount = 0;
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'h00, 1);
    checkOutput("postRstWrites", wrCount, 0);
    checkOutput("postRstRow", int'(wr_row), 0);
    checkOutput("postRstCol", int'(wr_col), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
